fv_ccp_multi_wr_port_queue: RTL

- Formal/DV modelling FIFO with NUM_WR_PORTS push ports and one pop port.
- Successor to the single-write-port CCP queue model: parametrised port count, non-power-of-2 depth, explicit occupancy count, same-cycle bypass, and sticky overflow/underflow flags.
- Instantiated inside CCP formal testbenches to model in-order write data that may arrive on several ports in one cycle.
- Carries its own protocol assertions.

---
 rtl/fv_ccp_multi_wr_port_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/fv_ccp_multi_wr_port_queue.sv
// fv_ccp_multi_wr_port_queue: multi-push-port, single-pop modelling FIFO with bypass and sticky error flags
module fv_ccp_multi_wr_port_queue #(
   parameter int WR_QUEUE_DEPTH  = 8,
   parameter int NUM_WR_PORTS    = 2,
   parameter int MEM_W           = 4,
   parameter int PNT_W           = $clog2(WR_QUEUE_DEPTH),
   parameter int CNT_W           = $clog2(WR_QUEUE_DEPTH+1),
   parameter bit PROTOCOL_CHECKS = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_WR_PORTS-1:0]       push,
   input  logic [NUM_WR_PORTS*MEM_W-1:0] data_in,
   input  logic                          pop,
   input  logic                          sample_fifo_output,
   output logic [MEM_W-1:0]              data_out,
   output logic                          empty,
   output logic                          full,
   output logic [CNT_W-1:0]              count,
   output logic                          overflow_err,
   output logic                          underflow_err
);
   localparam int AW = CNT_W + 3;
   logic [MEM_W-1:0] mem [WR_QUEUE_DEPTH];
   logic [PNT_W-1:0] wr_pnt, rd_pnt, wr_nxt, rd_nxt;
   logic [PNT_W-1:0] waddr [NUM_WR_PORTS];
   logic [NUM_WR_PORTS-1:0] wen;
   logic [AW-1:0] npush, written, space, slot, wsum;
   logic [MEM_W-1:0] bypass_data;
   logic pop_eff, norm_pop, bypass, skip, dropped, underflow;

   assign empty    = count == '0;
   assign full     = count == CNT_W'(WR_QUEUE_DEPTH);
   assign data_out = empty ? bypass_data : mem[rd_pnt];

   // Bypass source selection, in-order acceptance against free space, and slot assignment
   always_comb begin
      bypass_data = data_in[MEM_W-1:0];
      npush = '0;
      for (int i = NUM_WR_PORTS-1; i >= 0; i--) begin
         if (push[i]) bypass_data = data_in[i*MEM_W +: MEM_W];
         npush = npush + AW'(push[i]);
      end
      pop_eff   = pop && (!empty || |push);
      norm_pop  = pop_eff && !empty;
      bypass    = pop_eff && empty;
      underflow = pop && empty && !(|push);
      space     = AW'(WR_QUEUE_DEPTH) - AW'(count) + AW'(norm_pop);
      skip      = bypass;
      written   = '0;
      dropped   = 1'b0;
      wen       = '0;
      slot      = '0;
      for (int i = 0; i < NUM_WR_PORTS; i++) begin
         slot = AW'(wr_pnt) + written;
         if (slot >= AW'(WR_QUEUE_DEPTH)) slot = slot - AW'(WR_QUEUE_DEPTH);
         waddr[i] = PNT_W'(slot);
         if (push[i]) begin
            if (skip) skip = 1'b0;
            else if (written < space) begin
               wen[i]  = 1'b1;
               written = written + AW'(1);
            end else dropped = 1'b1;
         end
      end
      wsum   = AW'(wr_pnt) + written;
      wr_nxt = PNT_W'(wsum >= AW'(WR_QUEUE_DEPTH) ? wsum - AW'(WR_QUEUE_DEPTH) : wsum);
      rd_nxt = rd_pnt == PNT_W'(WR_QUEUE_DEPTH-1) ? '0 : rd_pnt + PNT_W'(1);
   end

   // Pointer, occupancy and sticky error state with asynchronous clear
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_pnt        <= '0;
         rd_pnt        <= '0;
         count         <= '0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         wr_pnt <= wr_nxt;
         if (norm_pop) rd_pnt <= rd_nxt;
         count <= CNT_W'(AW'(count) + written - AW'(norm_pop));
         if (dropped) overflow_err <= 1'b1;
         if (underflow) underflow_err <= 1'b1;
      end

   // Entry storage; contents deliberately survive reset
   always_ff @(posedge clk)
      for (int i = 0; i < NUM_WR_PORTS; i++)
         if (wen[i]) mem[waddr[i]] <= data_in[i*MEM_W +: MEM_W];

   no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !PROTOCOL_CHECKS || !dropped);
   no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
      !PROTOCOL_CHECKS || !(empty && npush == '0 && pop));
   no_sample_when_empty: assert property (@(posedge clk) disable iff (!reset_n)
      !PROTOCOL_CHECKS || !(empty && npush == '0 && sample_fifo_output));
   count_bound: assert property (@(posedge clk) disable iff (!reset_n)
      count <= CNT_W'(WR_QUEUE_DEPTH));
   full_empty_excl: assert property (@(posedge clk) disable iff (!reset_n)
      !(full && empty));

   cov_full: cover property (@(posedge clk) disable iff (!reset_n) full);
   cov_all_ports: cover property (@(posedge clk) disable iff (!reset_n) &push);
   cov_bypass_extra: cover property (@(posedge clk) disable iff (!reset_n)
      bypass && npush > AW'(1));
   cov_wrap_multi: cover property (@(posedge clk) disable iff (!reset_n)
      written > AW'(1) && wsum >= AW'(WR_QUEUE_DEPTH));
endmodule
